fetch_top: RTL and testbench
============================

FETCH_TOP -- requirements
Module: fetch_top

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning PC fetched first after reset.
REQ-002 Parameter BUBBLE_INST, default 32'h0000_0013, meaning NOP (addi x0,x0,0) injected as a bubble.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 imem_req  output  1  instruction fetch request.
REQ-006 imem_addr  output  32  fetch address.
REQ-007 imem_rdata  input  32  instruction returned for imem_addr.
REQ-008 imem_ready  input  1  imem_rdata valid this cycle.
REQ-009 intrlock_bubble  input  1  decode load-use stall; hold fetch.
REQ-010 ex_branch_flush  input  1  execute-stage mispredict/redirect.
REQ-011 ex_branch_target  input  32  correct PC on flush.
REQ-012 if_inst  output  32  IF/ID instruction to decode.
REQ-013 if_pc  output  32  IF/ID PC.
REQ-014 if_branch_taken  output  1  static prediction taken for if_inst.
REQ-015 if_branch_nt_pc  output  32  if_pc+4, fall-through PC.

Function
REQ-016 The block SHALL hold a PC register pc_q and an IF/ID register {if_inst, if_pc, if_branch_taken, if_branch_nt_pc}.
REQ-017 imem_addr SHALL equal pc_q combinationally; imem_req SHALL be 1 in RUN and WAIT, 0 in BOOT.
REQ-018 FSM states: BOOT (first cycle after reset release), RUN, WAIT (imem not ready).
REQ-019 Transitions: BOOT->RUN unconditionally; RUN->WAIT when imem_ready=0 and no flush; WAIT->RUN when imem_ready=1 or flush; all others stay.
REQ-020 Predecode of imem_rdata: opcode JAL (7'b1101111) -> taken, target pc_q+J-imm; opcode BRANCH (7'b1100011) with B-imm bit 31 = 1 (backward) -> taken, target pc_q+B-imm; all else (including JALR) -> not taken, target pc_q+4.
REQ-021 All PC arithmetic SHALL be 32-bit modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000).
REQ-022 Accept condition: imem_ready=1, imem_req=1, intrlock_bubble=0, ex_branch_flush=0; on accept, IF/ID <= {imem_rdata, pc_q, taken, pc_q+4} and pc_q <= predicted target next cycle.
REQ-023 intrlock_bubble=1 (no flush): pc_q and IF/ID SHALL hold unchanged; imem response that cycle is discarded and refetched.
REQ-024 imem_ready=0 (no flush, no interlock): pc_q holds; IF/ID <= {BUBBLE_INST, pc_q, 0, pc_q+4}.
REQ-025 ex_branch_flush=1 SHALL have highest priority over interlock and imem_ready: pc_q <= {ex_branch_target[31:2],2'b00}; IF/ID <= {BUBBLE_INST, if_pc, 0, if_pc+4}; state -> RUN.
REQ-026 Latency: instruction at address A appears on if_inst exactly one cycle after the accept cycle with imem_addr=A.
REQ-027 Bubbles SHALL never report if_branch_taken=1.

Reset
REQ-028 On rst_n=0, asynchronously: pc_q=RESET_PC, state=BOOT, if_inst=BUBBLE_INST, if_pc=RESET_PC, if_branch_taken=0, if_branch_nt_pc=RESET_PC+4.
REQ-029 Reset asserted mid-WAIT or mid-interlock SHALL discard all in-flight state; first imem_req after release is in cycle 2 with imem_addr=RESET_PC.

Verification
REQ-030 Reset release, imem_ready=1, sequential NOPs -> imem_addr 0x0,0x4,0x8 on consecutive RUN cycles; if_pc follows one cycle later; if_inst=BUBBLE_INST until first accept.
REQ-031 PC 0x100 fetches BEQ with B-imm -8 -> if_branch_taken=1, if_branch_nt_pc=0x104, next imem_addr=0xF8; forward BEQ +8 -> taken=0, next 0x104; JAL +0x20 at 0x200 -> next 0x220.
REQ-032 intrlock_bubble=1 for 2 cycles at pc_q=0x40 -> if_inst/if_pc frozen, imem_addr stays 0x40; resumes with 0x40 accepted on release.
REQ-033 imem_ready=0 for 3 cycles at 0x80 -> state WAIT, three BUBBLE_INST on if_inst, pc_q=0x80 held, 0x80 instruction delivered after ready.
REQ-034 ex_branch_flush=1 with target 0x303 simultaneous with intrlock_bubble=1 and imem_ready=0 -> next imem_addr=0x300, if_inst=BUBBLE_INST, if_branch_taken=0.
REQ-035 pc_q=0xFFFF_FFFC with NOP fetched -> next imem_addr=0x0000_0000, if_branch_nt_pc=0x0000_0000.

Source files
------------

// File: rtl/fetch_top_if.sv
// Instruction-fetch bus between the fetch stage, the instruction memory and
// the decode/execute stages. The master side is the fetch stage.
interface fetch_top_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        intrlock_bubble;
    logic        ex_branch_flush;
    logic [31:0] ex_branch_target;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_branch_taken;
    logic [31:0] if_branch_nt_pc;

    modport master (
        output imem_req, imem_addr, if_inst, if_pc, if_branch_taken, if_branch_nt_pc,
        input  imem_rdata, imem_ready, intrlock_bubble, ex_branch_flush, ex_branch_target
    );

    modport slave (
        input  imem_req, imem_addr, if_inst, if_pc, if_branch_taken, if_branch_nt_pc,
        output imem_rdata, imem_ready, intrlock_bubble, ex_branch_flush, ex_branch_target
    );
endinterface

// File: rtl/fetch_top.sv
// Fetch stage: PC register, static branch predecode (JAL / backward branch
// taken) and the IF/ID pipeline register, with stall, wait and flush handling.
module fetch_top #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INST = 32'h0000_0013
) (
    input logic         clk,
    input logic         rst_n,
    fetch_top_if.master bus
);
    typedef enum logic [1:0] {BOOT, RUN, WAIT} state_t;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t      state_q, state_d;
    logic        req_q;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic        taken_q, taken_d;
    logic [31:0] ntpc_q, ntpc_d;

    logic [31:0] j_imm, b_imm, pc_plus4, pred_target;
    logic        pred_taken;

    assign bus.imem_req        = req_q;
    assign bus.imem_addr       = pc_q;
    assign bus.if_inst         = inst_q;
    assign bus.if_pc           = ifpc_q;
    assign bus.if_branch_taken = taken_q;
    assign bus.if_branch_nt_pc = ntpc_q;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        j_imm = {{12{bus.imem_rdata[31]}}, bus.imem_rdata[19:12], bus.imem_rdata[20],
                 bus.imem_rdata[30:21], 1'b0};
        b_imm = {{20{bus.imem_rdata[31]}}, bus.imem_rdata[7], bus.imem_rdata[30:25],
                 bus.imem_rdata[11:8], 1'b0};
        pred_taken  = 1'b0;
        pred_target = pc_plus4;
        if (bus.imem_rdata[6:0] == OP_JAL) begin
            pred_taken  = 1'b1;
            pred_target = pc_q + j_imm;
        end else if (bus.imem_rdata[6:0] == OP_BRANCH && bus.imem_rdata[31]) begin
            pred_taken  = 1'b1;
            pred_target = pc_q + b_imm;
        end
    end

    // Flush outranks interlock and memory wait; BOOT only advances to RUN.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        ifpc_d  = ifpc_q;
        taken_d = taken_q;
        ntpc_d  = ntpc_q;
        if (bus.ex_branch_flush) begin
            state_d = RUN;
            pc_d    = bus.ex_branch_target & ~32'h3;
            inst_d  = BUBBLE_INST;
            taken_d = 1'b0;
            ntpc_d  = ifpc_q + 32'd4;
        end else if (state_q == BOOT) begin
            state_d = RUN;
        end else begin
            state_d = bus.imem_ready ? RUN : WAIT;
            if (bus.intrlock_bubble) begin
                // hold everything; this cycle's response is refetched later
            end else if (!bus.imem_ready) begin
                inst_d  = BUBBLE_INST;
                ifpc_d  = pc_q;
                taken_d = 1'b0;
                ntpc_d  = pc_plus4;
            end else begin
                pc_d    = pred_target;
                inst_d  = bus.imem_rdata;
                ifpc_d  = pc_q;
                taken_d = pred_taken;
                ntpc_d  = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            req_q   <= 1'b0;
            pc_q    <= RESET_PC;
            inst_q  <= BUBBLE_INST;
            ifpc_q  <= RESET_PC;
            taken_q <= 1'b0;
            ntpc_q  <= RESET_PC + 32'd4;
        end else begin
            state_q <= state_d;
            req_q   <= (state_d != BOOT);
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            ifpc_q  <= ifpc_d;
            taken_q <= taken_d;
            ntpc_q  <= ntpc_d;
        end
    end
endmodule

// File: tb/tb_fetch_top.sv
// Bench for fetch_top: directed scenarios plus a randomized run compared
// against a cycle-level behavioural model of the fetch rules.
module tb_fetch_top;
    localparam logic [31:0] BUB = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    fetch_top_if bus();

    fetch_top #(.RESET_PC(32'h0000_0000), .BUBBLE_INST(BUB)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic        m_boot;
    logic [31:0] m_pc, m_inst, m_ifpc, m_nt;
    logic        m_tk;

    function automatic logic [31:0] enc_b(input logic [31:0] imm);
        return {imm[12], imm[10:5], 13'd0, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'b1101111};
    endfunction

    function automatic logic [31:0] predict(input logic [31:0] pc, input logic [31:0] inst,
                                            output logic tk);
        int imm;
        tk = 1'b0;
        if (inst[6:0] == 7'b1101111) begin
            imm = int'(inst[30:21]) * 2 + int'(inst[20]) * 2048 + int'(inst[19:12]) * 4096
                  - (inst[31] ? (1 << 20) : 0);
            tk = 1'b1;
            return pc + 32'(imm);
        end
        if (inst[6:0] == 7'b1100011 && inst[31]) begin
            imm = int'(inst[11:8]) * 2 + int'(inst[30:25]) * 32 + int'(inst[7]) * 2048 - 4096;
            tk = 1'b1;
            return pc + 32'(imm);
        end
        return pc + 32'd4;
    endfunction

    task automatic m_reset();
        m_boot = 1'b1; m_pc = 32'h0; m_inst = BUB; m_ifpc = 32'h0; m_tk = 1'b0; m_nt = 32'h4;
    endtask

    task automatic step(input logic rdy, input logic bub, input logic fl,
                        input logic [31:0] tgt, input logic [31:0] rd);
        logic tk;
        logic [31:0] nxt;
        bus.imem_ready = rdy; bus.intrlock_bubble = bub; bus.ex_branch_flush = fl;
        bus.ex_branch_target = tgt; bus.imem_rdata = rd;
        if (fl) begin
            m_pc = {tgt[31:2], 2'b00}; m_inst = BUB; m_tk = 1'b0; m_nt = m_ifpc + 32'd4; m_boot = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (bub) begin
        end else if (!rdy) begin
            m_inst = BUB; m_ifpc = m_pc; m_tk = 1'b0; m_nt = m_pc + 32'd4;
        end else begin
            nxt = predict(m_pc, rd, tk);
            m_inst = rd; m_ifpc = m_pc; m_tk = tk; m_nt = m_pc + 32'd4; m_pc = nxt;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.imem_ready = 1'b0; bus.intrlock_bubble = 1'b0; bus.ex_branch_flush = 1'b0;
        bus.ex_branch_target = '0; bus.imem_rdata = '0;
        m_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({bus.imem_req, bus.imem_addr, bus.if_inst, bus.if_pc, bus.if_branch_taken, bus.if_branch_nt_pc}
            !== {1'b0, 32'h0, BUB, 32'h0, 1'b0, 32'h4}) begin
            bad++;
            $display("FAIL reset_state: got req=%b addr=%h inst=%h pc=%h tk=%b nt=%h want 0/0/%h/0/0/4",
                     bus.imem_req, bus.imem_addr, bus.if_inst, bus.if_pc, bus.if_branch_taken,
                     bus.if_branch_nt_pc, BUB);
        end
    endtask

    task automatic test_sequential();
        step(1'b1, 1'b0, 1'b0, 32'h0, BUB);
        total++;
        if ({bus.imem_req, bus.imem_addr, bus.if_inst} !== {1'b1, 32'h0, BUB}) begin
            bad++;
            $display("FAIL seq_first_req: got req=%b addr=%h inst=%h want 1/0/%h",
                     bus.imem_req, bus.imem_addr, bus.if_inst, BUB);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (bus.imem_addr !== 32'(4 * k)) begin
                bad++;
                $display("FAIL seq_addr%0d: got %h want %h", k, bus.imem_addr, 32'(4 * k));
            end
            step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0093 | (32'(k) << 20));
            total++;
            if ({bus.if_pc, bus.if_inst} !== {32'(4 * k), 32'h0000_0093 | (32'(k) << 20)}) begin
                bad++;
                $display("FAIL seq_ifid%0d: got pc=%h inst=%h want pc=%h", k, bus.if_pc,
                         bus.if_inst, 32'(4 * k));
            end
        end
    endtask

    task automatic test_branches();
        step(1'b0, 1'b0, 1'b1, 32'h100, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, enc_b(32'hFFFF_FFF8));
        total++;
        if ({bus.if_branch_taken, bus.if_branch_nt_pc, bus.imem_addr} !== {1'b1, 32'h104, 32'hF8}) begin
            bad++;
            $display("FAIL beq_back: got tk=%b nt=%h addr=%h want 1/104/f8",
                     bus.if_branch_taken, bus.if_branch_nt_pc, bus.imem_addr);
        end
        step(1'b0, 1'b0, 1'b1, 32'h100, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, enc_b(32'h8));
        total++;
        if ({bus.if_branch_taken, bus.imem_addr} !== {1'b0, 32'h104}) begin
            bad++;
            $display("FAIL beq_fwd: got tk=%b addr=%h want 0/104", bus.if_branch_taken, bus.imem_addr);
        end
        step(1'b0, 1'b0, 1'b1, 32'h200, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, enc_j(32'h20));
        total++;
        if ({bus.if_branch_taken, bus.imem_addr} !== {1'b1, 32'h220}) begin
            bad++;
            $display("FAIL jal: got tk=%b addr=%h want 1/220", bus.if_branch_taken, bus.imem_addr);
        end
    endtask

    task automatic test_interlock();
        logic [31:0] hold_inst, hold_pc;
        step(1'b0, 1'b0, 1'b1, 32'h40, 32'h0);
        hold_inst = bus.if_inst;
        hold_pc = bus.if_pc;
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 32'hDEAD_0033);
            total++;
            if ({bus.imem_addr, bus.if_inst, bus.if_pc} !== {32'h40, hold_inst, hold_pc}) begin
                bad++;
                $display("FAIL interlock_hold%0d: got addr=%h inst=%h pc=%h want 40/%h/%h",
                         k, bus.imem_addr, bus.if_inst, bus.if_pc, hold_inst, hold_pc);
            end
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0050_0113);
        total++;
        if ({bus.if_inst, bus.if_pc, bus.imem_addr} !== {32'h0050_0113, 32'h40, 32'h44}) begin
            bad++;
            $display("FAIL interlock_resume: got inst=%h pc=%h addr=%h want 00500113/40/44",
                     bus.if_inst, bus.if_pc, bus.imem_addr);
        end
    endtask

    task automatic test_wait();
        step(1'b0, 1'b0, 1'b1, 32'h80, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            total++;
            if ({bus.if_inst, bus.if_pc, bus.imem_addr, bus.if_branch_taken} !== {BUB, 32'h80, 32'h80, 1'b0}) begin
                bad++;
                $display("FAIL wait_bubble%0d: got inst=%h pc=%h addr=%h tk=%b want %h/80/80/0",
                         k, bus.if_inst, bus.if_pc, bus.imem_addr, bus.if_branch_taken, BUB);
            end
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0070_0193);
        total++;
        if ({bus.if_inst, bus.if_pc} !== {32'h0070_0193, 32'h80}) begin
            bad++;
            $display("FAIL wait_deliver: got inst=%h pc=%h want 00700193/80", bus.if_inst, bus.if_pc);
        end
    endtask

    task automatic test_flush();
        logic [31:0] old_pc;
        old_pc = bus.if_pc;
        step(1'b0, 1'b1, 1'b1, 32'h303, 32'h0);
        total++;
        if ({bus.imem_addr, bus.if_inst, bus.if_branch_taken, bus.if_pc, bus.if_branch_nt_pc}
            !== {32'h300, BUB, 1'b0, old_pc, old_pc + 32'd4}) begin
            bad++;
            $display("FAIL flush_prio: got addr=%h inst=%h tk=%b pc=%h nt=%h want 300/%h/0/%h/%h",
                     bus.imem_addr, bus.if_inst, bus.if_branch_taken, bus.if_pc, bus.if_branch_nt_pc,
                     BUB, old_pc, old_pc + 32'd4);
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, BUB);
        total++;
        if ({bus.imem_addr, bus.if_branch_nt_pc, bus.if_pc} !== {32'h0, 32'h0, 32'hFFFF_FFFC}) begin
            bad++;
            $display("FAIL pc_wrap: got addr=%h nt=%h pc=%h want 0/0/fffffffc",
                     bus.imem_addr, bus.if_branch_nt_pc, bus.if_pc);
        end
    endtask

    task automatic test_reset_midflight();
        step(1'b0, 1'b0, 1'b1, 32'h500, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.imem_req, bus.imem_addr, bus.if_inst, bus.if_pc, bus.if_branch_taken, bus.if_branch_nt_pc}
            !== {1'b0, 32'h0, BUB, 32'h0, 1'b0, 32'h4}) begin
            bad++;
            $display("FAIL async_reset: got req=%b addr=%h inst=%h pc=%h tk=%b nt=%h want 0/0/%h/0/0/4",
                     bus.imem_req, bus.imem_addr, bus.if_inst, bus.if_pc, bus.if_branch_taken,
                     bus.if_branch_nt_pc, BUB);
        end
        bus.intrlock_bubble = 1'b0;
        m_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        total++;
        if (bus.imem_req !== 1'b0) begin
            bad++;
            $display("FAIL boot_cycle1: got req=%b want 0", bus.imem_req);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, BUB);
        total++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
            bad++;
            $display("FAIL boot_cycle2: got req=%b addr=%h want 1/0", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_random();
        logic [31:0] inst, tgt;
        logic rdy, bub, fl;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0: inst = enc_j($urandom);
                1: inst = enc_b($urandom);
                2: inst = {$urandom_range(0, 32'h1FF_FFFF), 7'b1100111};
                default: inst = $urandom;
            endcase
            rdy = ($urandom_range(0, 9) < 8);
            bub = ($urandom_range(0, 9) < 2);
            fl = ($urandom_range(0, 19) == 0);
            tgt = (n % 50 == 7) ? 32'hFFFF_FFFF : $urandom;
            step(rdy, bub, fl, tgt, inst);
            total++;
            if ({bus.imem_req, bus.imem_addr, bus.if_inst, bus.if_pc, bus.if_branch_taken, bus.if_branch_nt_pc}
                !== {~m_boot, m_pc, m_inst, m_ifpc, m_tk, m_nt}) begin
                bad++;
                $display("FAIL random_cycle%0d: got req=%b addr=%h inst=%h pc=%h tk=%b nt=%h want req=%b addr=%h inst=%h pc=%h tk=%b nt=%h",
                         n, bus.imem_req, bus.imem_addr, bus.if_inst, bus.if_pc, bus.if_branch_taken,
                         bus.if_branch_nt_pc, ~m_boot, m_pc, m_inst, m_ifpc, m_tk, m_nt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branches();
        test_interlock();
        test_wait();
        test_flush();
        test_wrap();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
